// File: rtl/ahb_to_sram_ws.sv
// AHB-Lite slave to synchronous SRAM bridge: posted single-entry writes with read merge,
// 0..3 read wait states, and two-cycle ERROR responses for illegal transfers.
module ahb_to_sram_ws #(
  parameter int unsigned     AW        = 16,
  parameter int unsigned     DW        = 32,
  parameter int unsigned     RD_WS     = 0,
  parameter longint unsigned MEM_BYTES = 64'd1 << AW
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic                      HREADY,
  input  logic [1:0]                HTRANS,
  input  logic [2:0]                HSIZE,
  input  logic                      HWRITE,
  input  logic [AW-1:0]             HADDR,
  input  logic [DW-1:0]             HWDATA,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DW-1:0]             HRDATA,
  input  logic [DW-1:0]             SRAMRDATA,
  output logic [AW-$clog2(DW/8)-1:0] SRAMADDR,
  output logic [DW/8-1:0]           SRAMWEN,
  output logic [DW-1:0]             SRAMWDATA,
  output logic                      SRAMCS
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned WA = AW - LB;

  typedef enum logic [1:0] {IDLE, RDWAIT, ERR1, ERR2} state_t;
  state_t state, state_nxt;

  logic [1:0]    cnt, cnt_nxt;
  logic [WA-1:0] haddr_w, rd_addr, buf_addr;
  logic [NB-1:0] size_mask, lane_mask, buf_mask;
  logic [DW-1:0] buf_data;
  logic          wdp, pending, rd_hit;
  logic          acc, bad, misalign, good_rd, good_wr, retire;
  logic          unused_ok;

  assign unused_ok = &{1'b0, HTRANS[0]};
  assign haddr_w   = HADDR[AW-1:LB];

  always_comb begin
    misalign  = 1'b0;
    size_mask = '1;
    case (HSIZE)
      3'd0: size_mask = NB'(1);
      3'd1: begin size_mask = NB'(3);  misalign = HADDR[0];      end
      3'd2: begin size_mask = NB'(15); misalign = |HADDR[1:0];   end
      default: misalign = |HADDR[2:0];
    endcase
  end

  assign lane_mask = size_mask << HADDR[LB-1:0];
  assign bad       = (64'(HADDR) >= MEM_BYTES) | (HSIZE > 3'(LB)) | misalign;
  // Only IDLE and ERR2 end with HREADYOUT=1, so only they can own an address phase.
  assign acc       = HSEL & HREADY & HTRANS[1] & ((state == IDLE) | (state == ERR2));
  assign good_rd   = acc & ~bad & ~HWRITE;
  assign good_wr   = acc & ~bad & HWRITE;
  assign retire    = (wdp | pending) & ~good_rd & (state != RDWAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, ERR2: begin
        state_nxt = IDLE;
        if (acc & bad) begin
          state_nxt = ERR1;
        end else if (good_rd && (RD_WS != 0)) begin
          state_nxt = RDWAIT;
          cnt_nxt   = 2'(RD_WS);
        end
      end
      RDWAIT: begin
        if (cnt == 2'd1) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  assign HREADYOUT = ~((state == RDWAIT) | (state == ERR1));
  assign HRESP     = (state == ERR1) | (state == ERR2);

  always_comb begin
    SRAMCS   = 1'b0;
    SRAMADDR = buf_addr;
    SRAMWEN  = '0;
    if (good_rd) begin
      SRAMCS   = 1'b1;
      SRAMADDR = haddr_w;
    end else if (state == RDWAIT) begin
      SRAMCS   = 1'b1;
      SRAMADDR = rd_addr;
    end else if (retire) begin
      SRAMCS   = 1'b1;
      SRAMWEN  = buf_mask;
    end
  end

  assign SRAMWDATA = pending ? buf_data : HWDATA;

  always_comb begin
    HRDATA = SRAMRDATA;
    for (int unsigned i = 0; i < NB; i++)
      if (rd_hit & buf_mask[i]) HRDATA[8*i +: 8] = buf_data[8*i +: 8];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      wdp      <= 1'b0;
      pending  <= 1'b0;
      rd_hit   <= 1'b0;
      rd_addr  <= '0;
      buf_addr <= '0;
      buf_mask <= '0;
      buf_data <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wdp     <= good_wr;
      pending <= (wdp | pending) & ~retire;
      if (good_rd) begin
        rd_addr <= haddr_w;
        rd_hit  <= (haddr_w == buf_addr) & (wdp | pending);
      end
      if (good_wr) begin
        buf_addr <= haddr_w;
        buf_mask <= lane_mask;
      end
      if (wdp) begin
        for (int unsigned i = 0; i < NB; i++)
          if (buf_mask[i]) buf_data[8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_to_sram_ws.sv
// Directed bench for ahb_to_sram_ws: three configurations (32b/0ws/4KiB, 32b/2ws, 64b/1ws)
// sharing one AHB stimulus bus, each with its own behavioural SRAM.
`timescale 1ns/1ps
module tb_ahb_to_sram_ws;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [15:0] haddr;
  logic [63:0] hwdata;
  int ncmp = 0;
  int nfail = 0;

  always #5 HCLK = ~HCLK;

  logic        rdy0, resp0, cs0;
  logic [31:0] rdata0, srd0, wdata0;
  logic [13:0] addr0;
  logic [3:0]  wen0;
  logic        rdy1, resp1, cs1;
  logic [31:0] rdata1, srd1, wdata1;
  logic [13:0] addr1;
  logic [3:0]  wen1;
  logic        rdy2, resp2, cs2;
  logic [63:0] rdata2, srd2, wdata2;
  logic [12:0] addr2;
  logic [7:0]  wen2;

  ahb_to_sram_ws #(.AW(16), .DW(32), .RD_WS(0), .MEM_BYTES(64'h1000)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(rdy0), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata[31:0]),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0), .SRAMRDATA(srd0),
    .SRAMADDR(addr0), .SRAMWEN(wen0), .SRAMWDATA(wdata0), .SRAMCS(cs0));

  ahb_to_sram_ws #(.AW(16), .DW(32), .RD_WS(2)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(rdy1), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata[31:0]),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rdata1), .SRAMRDATA(srd1),
    .SRAMADDR(addr1), .SRAMWEN(wen1), .SRAMWDATA(wdata1), .SRAMCS(cs1));

  ahb_to_sram_ws #(.AW(16), .DW(64), .RD_WS(1)) u2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HREADY(rdy2), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2), .SRAMRDATA(srd2),
    .SRAMADDR(addr2), .SRAMWEN(wen2), .SRAMWDATA(wdata2), .SRAMCS(cs2));

  // SRAM models: read latency 1+RD_WS; fixed contents loaded while reset is held.
  logic [31:0] m0 [0:1023];
  logic [31:0] m1 [0:1023];
  logic [63:0] m2 [0:1023];
  logic [31:0] q1a, q1b;
  logic [63:0] q2a;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      m0[8]    <= 32'h11223344;
      m0[9]    <= 32'h55667788;
      m1[16]   <= 32'hCAFEF00D;
      m1[32]   <= 32'hA5A5A5A5;
      m2[0]    <= 64'h0011223344556677;
      m2[1]    <= 64'h8877665544332211;
    end else begin
      if (cs0) begin
        for (int b = 0; b < 4; b++) if (wen0[b]) m0[addr0[9:0]][8*b +: 8] <= wdata0[8*b +: 8];
        srd0 <= m0[addr0[9:0]];
      end
      if (cs1) begin
        for (int b = 0; b < 4; b++) if (wen1[b]) m1[addr1[9:0]][8*b +: 8] <= wdata1[8*b +: 8];
        q1a <= m1[addr1[9:0]];
      end
      if (cs2) begin
        for (int b = 0; b < 8; b++) if (wen2[b]) m2[addr2[9:0]][8*b +: 8] <= wdata2[8*b +: 8];
        q2a <= m2[addr2[9:0]];
      end
    end
    q1b  <= q1a;
    srd1 <= q1b;
    srd2 <= q2a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic idle();
    hsel   = 3'b000;
    htrans = 2'b00;
  endtask

  task automatic ap(input logic [2:0] sel, input logic w, input logic [2:0] sz, input logic [15:0] a);
    hsel   = sel;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
  endtask

  initial begin
    HRESETn = 1'b0;
    idle();
    hwrite = 1'b0;
    hsize  = 3'd0;
    haddr  = '0;
    hwdata = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst rdy0", rdy0, 1'b1);
    chk("rst resp0", resp0, 1'b0);
    chk("rst cs0", cs0, 1'b0);
    chk("rst wen0", wen0, 4'h0);
    chk("rst rdy1", rdy1, 1'b1);
    chk("rst cs2", cs2, 1'b0);
    HRESETn = 1'b1;

    // u0: word write then zero-wait read back
    cyc(); ap(3'b001, 1'b1, 3'd2, 16'h0010); look();
    chk("w1 addr-phase cs", cs0, 1'b0);
    cyc(); idle(); hwdata = 64'hDEADBEEF; look();
    chk("w1 retire cs", cs0, 1'b1);
    chk("w1 retire addr", addr0, 14'h4);
    chk("w1 retire wen", wen0, 4'hF);
    chk("w1 retire wdata", wdata0, 32'hDEADBEEF);
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0010); look();
    chk("r1 cs", cs0, 1'b1);
    chk("r1 addr", addr0, 14'h4);
    chk("r1 wen", wen0, 4'h0);
    cyc(); idle(); look();
    chk("r1 rdy", rdy0, 1'b1);
    chk("r1 data", rdata0, 32'hDEADBEEF);

    // u0: byte write colliding with back-to-back reads, merge and deferred retire
    cyc(); ap(3'b001, 1'b1, 3'd0, 16'h0021); look();
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0020); hwdata = 64'h0000AA00; look();
    chk("col rd cs", cs0, 1'b1);
    chk("col rd addr", addr0, 14'h8);
    chk("col rd wen", wen0, 4'h0);
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0024); look();
    chk("merge data", rdata0, 32'h1122AA44);
    chk("merge rdy", rdy0, 1'b1);
    chk("b2b rd addr", addr0, 14'h9);
    chk("b2b rd wen", wen0, 4'h0);
    cyc(); idle(); look();
    chk("b2b data", rdata0, 32'h55667788);
    chk("pend retire cs", cs0, 1'b1);
    chk("pend retire addr", addr0, 14'h8);
    chk("pend retire wen", wen0, 4'b0010);
    chk("pend retire lane", wdata0 & 32'h0000FF00, 32'h0000AA00);
    cyc(); look();
    chk("after retire cs", cs0, 1'b0);
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0020); look();
    cyc(); idle(); look();
    chk("retired data", rdata0, 32'h1122AA44);

    // u0: out-of-range read, misaligned write, read accepted in ERR2
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h1000); look();
    chk("oor addr cs", cs0, 1'b0);
    chk("oor addr resp", resp0, 1'b0);
    cyc(); idle(); look();
    chk("oor e1 rdy", rdy0, 1'b0);
    chk("oor e1 resp", resp0, 1'b1);
    chk("oor e1 cs", cs0, 1'b0);
    cyc(); look();
    chk("oor e2 rdy", rdy0, 1'b1);
    chk("oor e2 resp", resp0, 1'b1);
    chk("oor e2 cs", cs0, 1'b0);
    cyc(); ap(3'b001, 1'b1, 3'd1, 16'h0003); look();
    chk("mis addr cs", cs0, 1'b0);
    cyc(); idle(); hwdata = 64'h00001234; look();
    chk("mis e1 rdy", rdy0, 1'b0);
    chk("mis e1 resp", resp0, 1'b1);
    chk("mis e1 cs", cs0, 1'b0);
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0010); look();
    chk("mis e2 rdy", rdy0, 1'b1);
    chk("mis e2 resp", resp0, 1'b1);
    chk("e2 new rd cs", cs0, 1'b1);
    chk("e2 new rd addr", addr0, 14'h4);
    cyc(); idle(); look();
    chk("e2 rd data", rdata0, 32'hDEADBEEF);
    chk("e2 rd resp", resp0, 1'b0);
    cyc(); ap(3'b001, 1'b0, 3'd3, 16'h0000); look();
    chk("size addr cs", cs0, 1'b0);
    cyc(); idle(); look();
    chk("size e1 resp", resp0, 1'b1);
    chk("size e1 rdy", rdy0, 1'b0);
    cyc(); look();
    cyc(); ap(3'b001, 1'b0, 3'd2, 16'h0FFC); look();
    chk("top word cs", cs0, 1'b1);
    chk("top word addr", addr0, 14'h3FF);
    cyc(); idle(); look();
    chk("top word resp", resp0, 1'b0);
    chk("top word rdy", rdy0, 1'b1);

    // u1: two read wait states
    cyc(); ap(3'b010, 1'b0, 3'd2, 16'h0040); look();
    chk("ws a cs", cs1, 1'b1);
    chk("ws a addr", addr1, 14'h10);
    chk("ws a rdy", rdy1, 1'b1);
    cyc(); idle(); look();
    chk("ws d1 rdy", rdy1, 1'b0);
    chk("ws d1 cs", cs1, 1'b1);
    chk("ws d1 addr", addr1, 14'h10);
    cyc(); look();
    chk("ws d2 rdy", rdy1, 1'b0);
    chk("ws d2 cs", cs1, 1'b1);
    chk("ws d2 addr", addr1, 14'h10);
    cyc(); look();
    chk("ws d3 rdy", rdy1, 1'b1);
    chk("ws d3 data", rdata1, 32'hCAFEF00D);
    chk("ws d3 cs", cs1, 1'b0);

    // u1: reset during RDWAIT drops the pending write
    cyc(); ap(3'b010, 1'b1, 3'd2, 16'h0080); look();
    chk("rw addr cs", cs1, 1'b0);
    cyc(); ap(3'b010, 1'b0, 3'd2, 16'h0040); hwdata = 64'h12345678; look();
    chk("rw rd cs", cs1, 1'b1);
    chk("rw rd wen", wen1, 4'h0);
    cyc(); idle(); look();
    chk("rw wait rdy", rdy1, 1'b0);
    chk("rw wait wen", wen1, 4'h0);
    #1 HRESETn = 1'b0;
    #1;
    chk("mid rst rdy", rdy1, 1'b1);
    chk("mid rst resp", resp1, 1'b0);
    chk("mid rst cs", cs1, 1'b0);
    chk("mid rst wen", wen1, 4'h0);
    cyc(); HRESETn = 1'b1; look();
    chk("post rst cs a", cs1, 1'b0);
    cyc(); look();
    chk("post rst cs b", cs1, 1'b0);
    chk("post rst wen b", wen1, 4'h0);
    cyc(); ap(3'b010, 1'b0, 3'd2, 16'h0080); look();
    chk("dropped rd addr", addr1, 14'h20);
    cyc(); idle(); look();
    cyc(); look();
    cyc(); look();
    chk("dropped rdy", rdy1, 1'b1);
    chk("dropped data", rdata1, 32'hA5A5A5A5);

    // u2: 64-bit halfword write, read back, and byte merge with one wait state
    cyc(); ap(3'b100, 1'b1, 3'd1, 16'h0006); look();
    cyc(); idle(); hwdata = 64'hBEEF_0000_0000_0000; look();
    chk("hw cs", cs2, 1'b1);
    chk("hw addr", addr2, 13'h0);
    chk("hw wen", wen2, 8'hC0);
    chk("hw wdata hi", {48'h0, wdata2[63:48]}, 64'hBEEF);
    cyc(); ap(3'b100, 1'b0, 3'd3, 16'h0000); look();
    chk("dw rd cs", cs2, 1'b1);
    chk("dw rd wen", wen2, 8'h00);
    cyc(); idle(); look();
    chk("dw d1 rdy", rdy2, 1'b0);
    cyc(); look();
    chk("dw d2 rdy", rdy2, 1'b1);
    chk("dw d2 data", rdata2, 64'hBEEF223344556677);
    cyc(); ap(3'b100, 1'b1, 3'd0, 16'h0009); look();
    cyc(); ap(3'b100, 1'b0, 3'd3, 16'h0008); hwdata = 64'h0000_0000_0000_5A00; look();
    chk("m64 rd addr", addr2, 13'h1);
    chk("m64 rd wen", wen2, 8'h00);
    cyc(); idle(); look();
    chk("m64 d1 rdy", rdy2, 1'b0);
    chk("m64 d1 cs", cs2, 1'b1);
    chk("m64 d1 wen", wen2, 8'h00);
    cyc(); look();
    chk("m64 d2 data", rdata2, 64'h8877665544335A11);
    chk("m64 retire addr", addr2, 13'h1);
    chk("m64 retire wen", wen2, 8'h02);
    chk("m64 retire lane", wdata2 & 64'hFF00, 64'h5A00);
    cyc(); look();
    chk("m64 done cs", cs2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000ns");
    $fatal(1, "timeout");
  end
endmodule
